// File: rtl/nn_neuron_seq_if.sv
// Control, data and status bundle for the sequential neuron engine.
// The master drives operands and weight writes; the slave returns results and flags.
interface nn_neuron_seq_if #(
  parameter int WIDTH = 32,
  parameter int NIN   = 4
);
  localparam int AW = $clog2(NIN + 1);

  logic                   enable;
  logic                   relu_en;
  logic [NIN*WIDTH-1:0]   in_data;
  logic                   w_we;
  logic [AW-1:0]          w_addr;
  logic [WIDTH-1:0]       w_data;
  logic [WIDTH-1:0]       final_output;
  logic                   total_ovf;
  logic                   total_zero;
  logic [2:0]             ovf_fsm_stage;
  logic [2:0]             zero_fsm_stage;
  logic                   busy;
  logic                   done;

  modport master (
    output enable, relu_en, in_data, w_we, w_addr, w_data,
    input  final_output, total_ovf, total_zero, ovf_fsm_stage, zero_fsm_stage, busy, done
  );

  modport slave (
    input  enable, relu_en, in_data, w_we, w_addr, w_data,
    output final_output, total_ovf, total_zero, ovf_fsm_stage, zero_fsm_stage, busy, done
  );
endinterface

// File: rtl/nn_neuron_seq.sv
// Sequential neuron: one signed multiply-accumulate per cycle over NIN inputs,
// then bias add, optional ReLU, with sticky overflow and zero-stage diagnostics.
module nn_neuron_seq #(
  parameter int WIDTH = 32,
  parameter int NIN   = 4,
  parameter int FRAC  = 0
) (
  input  logic           clk,
  input  logic           reset,
  nn_neuron_seq_if.slave bus
);
  localparam int AW = $clog2(NIN + 1);

  typedef enum logic [2:0] {
    ST_DEACT = 3'b000,
    ST_LOAD  = 3'b001,
    ST_MAC   = 3'b010,
    ST_BIAS  = 3'b011,
    ST_ACT   = 3'b100,
    ST_OUT   = 3'b101,
    ST_IDLE  = 3'b110
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_in [NIN];
  logic signed [WIDTH-1:0] r_w  [NIN];
  logic signed [WIDTH-1:0] r_bias;
  logic signed [WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0] r_final;
  logic [AW-1:0]           r_idx;
  logic                    r_relu;
  logic                    r_ovf;
  logic                    r_zero;
  logic [2:0]              r_ovf_stage;
  logic [2:0]              r_zero_stage;
  logic                    r_busy;
  logic                    r_done;

  logic signed [WIDTH-1:0]   w_x;
  logic signed [WIDTH-1:0]   w_wt;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_shift;
  logic signed [WIDTH-1:0]   w_s;
  logic signed [WIDTH-1:0]   w_mac_sum;
  logic signed [WIDTH-1:0]   w_bias_sum;
  logic signed [WIDTH-1:0]   w_act;
  logic                      w_mac_ovf;
  logic                      w_bias_ovf;
  logic                      w_cfg_ok;

  function automatic logic prod_fits(input logic signed [2*WIDTH-1:0] v);
    return v[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){v[WIDTH-1]}};
  endfunction

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    w_x  = '0;
    w_wt = '0;
    for (int k = 0; k < NIN; k++) begin
      if (r_idx == AW'(k)) begin
        w_x  = r_in[k];
        w_wt = r_w[k];
      end
    end
  end

  // Operands are sign-extended to full width so the product never wraps.
  assign w_prod     = $signed({{WIDTH{w_x[WIDTH-1]}}, w_x}) * $signed({{WIDTH{w_wt[WIDTH-1]}}, w_wt});
  assign w_shift    = w_prod >>> FRAC;
  assign w_s        = w_shift[WIDTH-1:0];
  assign w_mac_sum  = r_acc + w_s;
  assign w_bias_sum = r_acc + r_bias;
  assign w_mac_ovf  = !prod_fits(w_shift) || add_ovf(r_acc, w_s, w_mac_sum);
  assign w_bias_ovf = add_ovf(r_acc, r_bias, w_bias_sum);
  assign w_act      = (r_relu && r_acc[WIDTH-1]) ? '0 : r_acc;
  assign w_cfg_ok   = (r_state == ST_DEACT) || (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_DEACT;
      r_bias       <= '0;
      r_acc        <= '0;
      r_final      <= '0;
      r_idx        <= '0;
      r_relu       <= 1'b0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b0;
      r_ovf_stage  <= 3'b000;
      r_zero_stage <= 3'b000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int k = 0; k < NIN; k++) begin
        r_in[k] <= '0;
        r_w[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      // Writes land before LOAD reads the weights, so a same-cycle enable sees them.
      if (w_cfg_ok && bus.w_we) begin
        for (int k = 0; k < NIN; k++) begin
          if (bus.w_addr == AW'(k)) r_w[k] <= bus.w_data;
        end
        if (bus.w_addr == AW'(NIN)) r_bias <= bus.w_data;
      end
      case (r_state)
        ST_DEACT, ST_IDLE: begin
          if (bus.enable) begin
            r_state      <= ST_LOAD;
            r_relu       <= bus.relu_en;
            r_acc        <= '0;
            r_idx        <= '0;
            r_ovf        <= 1'b0;
            r_zero       <= 1'b0;
            r_ovf_stage  <= 3'b000;
            r_zero_stage <= 3'b000;
            r_final      <= '0;
            r_busy       <= 1'b1;
            for (int k = 0; k < NIN; k++) r_in[k] <= bus.in_data[k*WIDTH +: WIDTH];
          end
        end
        ST_LOAD: begin
          r_state <= ST_MAC;
          r_idx   <= '0;
        end
        ST_MAC, ST_BIAS: begin
          if ((r_state == ST_MAC) ? w_mac_ovf : w_bias_ovf) begin
            r_ovf       <= 1'b1;
            r_ovf_stage <= r_state;
            r_final     <= '1;
            r_zero      <= 1'b0;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (r_state == ST_MAC) begin
            r_acc <= w_mac_sum;
            if (w_mac_sum == '0 && r_zero_stage == 3'b000) r_zero_stage <= ST_MAC;
            if (r_idx == AW'(NIN - 1)) r_state <= ST_BIAS;
            else                       r_idx   <= r_idx + AW'(1);
          end else begin
            r_acc   <= w_bias_sum;
            if (w_bias_sum == '0 && r_zero_stage == 3'b000) r_zero_stage <= ST_BIAS;
            r_state <= ST_ACT;
          end
        end
        ST_ACT: begin
          r_acc   <= w_act;
          if (w_act == '0 && r_zero_stage == 3'b000) r_zero_stage <= ST_ACT;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_final <= r_acc;
          r_zero  <= (r_acc == '0);
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_DEACT;
      endcase
    end
  end

  assign bus.final_output   = r_final;
  assign bus.total_ovf      = r_ovf;
  assign bus.total_zero     = r_zero;
  assign bus.ovf_fsm_stage  = r_ovf_stage;
  assign bus.zero_fsm_stage = r_zero_stage;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
endmodule

// File: tb/tb_nn_neuron_seq.sv
// Directed bench for nn_neuron_seq (WIDTH=32, NIN=4, FRAC=0): vector table plus
// hand-written sequences for back-to-back runs, write lockout and mid-run reset.
module tb_nn_neuron_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nn_neuron_seq_if #(.WIDTH(32), .NIN(4)) bus ();

  nn_neuron_seq #(.WIDTH(32), .NIN(4), .FRAC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] w [4];
    logic [31:0] b;
    logic [31:0] x [4];
    logic        relu;
    logic [31:0] e_out;
    logic        e_ovf;
    logic        e_zero;
    logic [2:0]  e_ostg;
    logic [2:0]  e_zstg;
    int          e_cyc;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, b,
                              input logic [31:0] x0, x1, x2, x3,
                              input logic relu, input logic [31:0] eo,
                              input logic eovf, input logic ez,
                              input logic [2:0] eos, input logic [2:0] ezs, input int ec);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.b = b;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.relu = relu; v.e_out = eo; v.e_ovf = eovf; v.e_zero = ez;
    v.e_ostg = eos; v.e_zstg = ezs; v.e_cyc = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_w(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.w_we = 1'b1; bus.w_addr = addr; bus.w_data = data;
    @(posedge clk); #1;
    bus.w_we = 1'b0;
  endtask

  task automatic set_in(input logic [31:0] x0, x1, x2, x3);
    bus.in_data = {x3, x2, x1, x0};
  endtask

  task automatic start(input logic relu);
    @(negedge clk);
    bus.relu_en = relu; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    chk("busy_after_enable", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1;
        cyc = n;
      end
    end
    if (!seen) cyc = 999;
  endtask

  task automatic check_result(input string tag, input logic [31:0] eo, input logic eovf,
                              input logic ez, input logic [2:0] eos, input logic [2:0] ezs);
    chk({tag, "_out"},  64'(bus.final_output),   64'(eo));
    chk({tag, "_ovf"},  64'(bus.total_ovf),      64'(eovf));
    chk({tag, "_zero"}, 64'(bus.total_zero),     64'(ez));
    chk({tag, "_ostg"}, 64'(bus.ovf_fsm_stage),  64'(eos));
    chk({tag, "_zstg"}, 64'(bus.zero_fsm_stage), 64'(ezs));
    chk({tag, "_busy"}, 64'(bus.busy),           64'd0);
  endtask

  initial begin
    int cyc;
    bus.enable = 1'b0; bus.relu_en = 1'b0; bus.in_data = '0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;

    vecs[0] = mk(1, 2, 3, 4, 10,                       1, 1, 1, 1, 0, 20, 0, 0, 3'd0, 3'd0, 8);
    vecs[1] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
                 5, 5, 5, 5, 1, 0, 0, 1, 3'd0, 3'd4, 8);
    vecs[2] = mk(32'h7FFFFFFF, 0, 0, 0, 0,             2, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 3'd2, 3'd0, 2);
    vecs[3] = mk(1, 0, 0, 0, 1,                        32'h7FFFFFFF, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 3'd3, 3'd0, 6);
    vecs[4] = mk(32'hFFFFFFFE, 3, 0, 0, 32'hFFFFFFFC,  5, 1, 0, 0, 0, 32'hFFFFFFF5, 0, 0, 3'd0, 3'd0, 8);
    vecs[5] = mk(2, 2, 2, 2, 32'hFFFFFFFB,             1, 2, 3, 4, 1, 15, 0, 0, 3'd0, 3'd0, 8);
    vecs[6] = mk(1, 32'hFFFFFFFF, 0, 0, 0,             3, 3, 0, 0, 0, 0, 0, 1, 3'd0, 3'd2, 8);
    vecs[7] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0,  1, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 3'd2, 3'd0, 3);
    vecs[8] = mk(32'h80000000, 0, 0, 0, 0,             32'hFFFFFFFF, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 3'd2, 3'd0, 2);
    vecs[9] = mk(32'h80000000, 0, 0, 0, 0,             1, 0, 0, 0, 0, 32'h80000000, 0, 0, 3'd0, 3'd0, 8);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",  64'(bus.final_output), 64'd0);
    chk("rst_ovf",  64'(bus.total_ovf),    64'd0);
    chk("rst_zero", 64'(bus.total_zero),   64'd0);
    chk("rst_busy", 64'(bus.busy),         64'd0);
    chk("rst_done", 64'(bus.done),         64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) write_w(3'(k), vecs[i].w[k]);
      write_w(3'd4, vecs[i].b);
      set_in(vecs[i].x[0], vecs[i].x[1], vecs[i].x[2], vecs[i].x[3]);
      start(vecs[i].relu);
      wait_done(cyc);
      chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].e_cyc));
      check_result($sformatf("v%0d", i), vecs[i].e_out, vecs[i].e_ovf, vecs[i].e_zero,
                   vecs[i].e_ostg, vecs[i].e_zstg);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      chk($sformatf("v%0d_hold", i), 64'(bus.final_output), 64'(vecs[i].e_out));
    end

    // Back-to-back with a write attempted while busy.
    write_w(3'd0, 1); write_w(3'd1, 2); write_w(3'd2, 3); write_w(3'd3, 4); write_w(3'd4, 10);
    set_in(1, 1, 1, 1);
    start(1'b0);
    write_w(3'd0, 99);
    wait_done(cyc);
    chk("b2b_run1_latency", 64'(cyc), 64'd7);
    check_result("b2b_run1", 20, 0, 0, 3'd0, 3'd0);
    start(1'b0);
    wait_done(cyc);
    chk("b2b_run2_latency", 64'(cyc), 64'd8);
    check_result("b2b_run2", 20, 0, 0, 3'd0, 3'd0);

    // Write and enable in the same cycle: new weight is used.
    @(negedge clk);
    bus.w_we = 1'b1; bus.w_addr = 3'd0; bus.w_data = 99;
    bus.relu_en = 1'b0; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.w_we = 1'b0; bus.enable = 1'b0;
    wait_done(cyc);
    chk("wr_en_latency", 64'(cyc), 64'd8);
    check_result("wr_en", 118, 0, 0, 3'd0, 3'd0);

    // Reset while at MAC index 2.
    start(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out",  64'(bus.final_output),   64'd0);
    chk("mid_rst_ovf",  64'(bus.total_ovf),      64'd0);
    chk("mid_rst_zero", 64'(bus.total_zero),     64'd0);
    chk("mid_rst_ostg", 64'(bus.ovf_fsm_stage),  64'd0);
    chk("mid_rst_zstg", 64'(bus.zero_fsm_stage), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy),           64'd0);
    chk("mid_rst_done", 64'(bus.done),           64'd0);
    @(negedge clk);
    reset = 1'b0;
    set_in(7, 7, 7, 7);
    start(1'b0);
    wait_done(cyc);
    chk("post_rst_latency", 64'(cyc), 64'd8);
    check_result("post_rst", 0, 0, 1, 3'd0, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
